// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Multiplies use radix-2 shift-add and divides use restoring shift-subtract, one
// bit per cycle, followed by a single sign-correction cycle. Also services mthi/mtlo.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_E,
    input  logic [1:0]      op_E,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            mthi_E,
    input  logic            mtlo_E,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opB_q, opB_d;
    logic                isDiv_q, isDiv_d;
    logic                negRes_q, negRes_d;
    logic                negRem_q, negRem_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic                dbzPend_q, dbzPend_d;

    // Operand decode and per-iteration datapath for both algorithms.
    logic                opSigned;
    logic                opDiv;
    logic                aNeg;
    logic                bNeg;
    logic [XLEN-1:0]     aMag;
    logic [XLEN-1:0]     bMag;
    logic [XLEN:0]       mulAdd;
    logic [XLEN:0]       mulSum;
    logic [2*XLEN-1:0]   mulNext;
    logic [XLEN:0]       divShift;
    logic [XLEN:0]       divDiff;
    logic [2*XLEN-1:0]   divNext;
    logic [2*XLEN-1:0]   prodFix;
    logic [XLEN-1:0]     quotFix;
    logic [XLEN-1:0]     remFix;

    // Combinational datapath: operand magnitudes, one shift-add / shift-subtract step, sign fixup.
    always_comb begin
        opSigned = ~op_E[0];
        opDiv    = op_E[1];
        aNeg     = opSigned & src_a[XLEN-1];
        bNeg     = opSigned & src_b[XLEN-1];
        aMag     = aNeg ? -src_a : src_a;
        bMag     = bNeg ? -src_b : src_b;

        mulAdd   = acc_q[0] ? {1'b0, opB_q} : '0;
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + mulAdd;
        mulNext  = {mulSum, acc_q[XLEN-1:1]};

        divShift = acc_q[2*XLEN-1:XLEN-1];
        divDiff  = divShift - {1'b0, opB_q};
        divNext  = divDiff[XLEN] ? {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {divDiff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

        prodFix  = negRes_q ? -acc_q : acc_q;
        quotFix  = negRes_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remFix   = negRem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    // Next-state logic: issue/mthi/mtlo in IDLE, iterate in CALC, commit in FIXUP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        isDiv_d   = isDiv_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        dbzPend_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (dbzPend_q) begin
                    done_d = 1'b1;
                    dbz_d  = 1'b1;
                end
                if (start_E) begin
                    if (opDiv && (src_b == '0)) begin
                        dbzPend_d = 1'b1;
                    end else begin
                        acc_d    = {{XLEN{1'b0}}, opDiv ? aMag : bMag};
                        opB_d    = opDiv ? bMag : aMag;
                        isDiv_d  = opDiv;
                        negRes_d = aNeg ^ bNeg;
                        negRem_d = opDiv & aNeg;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = CALC;
                    end
                end else begin
                    if (mthi_E) begin
                        hi_d = src_a;
                    end
                    if (mtlo_E) begin
                        lo_d = src_a;
                    end
                end
            end
            CALC: begin
                acc_d = isDiv_q ? divNext : mulNext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (isDiv_q) begin
                    hi_d = remFix;
                    lo_d = quotFix;
                end else begin
                    hi_d = prodFix[2*XLEN-1:XLEN];
                    lo_d = prodFix[XLEN-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            dbzPend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            isDiv_q   <= isDiv_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            dbzPend_q <= dbzPend_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
